fpu_mult_pipe: RTL and testbench
================================

FPU_MULT_PIPE -- requirements
Module: fpu_mult_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width.
REQ-002 SHALL have parameter MAN_W, default 23, stored fraction width.
REQ-003 SHALL define the operand width as W = 1+EXP_W+MAN_W and the exponent bias as BIAS = 2^(EXP_W-1)-1; default W = 32.
REQ-004 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port input_a, input, W, operand A (IEEE-754 style layout: sign | exponent | fraction).
REQ-007 SHALL have port input_b, input, W, operand B.
REQ-008 SHALL have port input_stb, input, 1, operands valid.
REQ-009 SHALL have port input_ack, output, 1, block can accept operands this cycle.
REQ-010 SHALL have port output_z, output, W, product.
REQ-011 SHALL have port output_flags, output, 4, {invalid, overflow, underflow, inexact} for output_z.
REQ-012 SHALL have port output_stb, output, 1, output_z/output_flags valid.
REQ-013 SHALL have port output_ack, input, 1, consumer takes the result this cycle.

Function
REQ-014 SHALL transfer operands on any rising edge where input_stb=1 and input_ack=1; SHALL transfer a result on any edge where output_stb=1 and output_ack=1.
REQ-015 SHALL be a 4-stage pipeline: S1 unpack/classify, S2 significand multiply, S3 normalise, S4 round/pack/flags; each stage carries a valid bit.
REQ-016 SHALL use global enable en = !output_stb || output_ack; input_ack = en; all stages advance only when en=1.
REQ-017 SHALL assert output_stb 4 cycles after acceptance when unstalled, with throughput of one result per cycle.
REQ-018 SHALL hold output_z, output_flags and output_stb stable while output_stb=1 and output_ack=0.
REQ-019 SHALL deliver results in acceptance order, with none dropped or duplicated under any stall pattern.
REQ-020 SHALL compute the sign as sign_a XOR sign_b for every result, including zero, inf and NaN.
REQ-021 SHALL, for normal operands, form the (2*MAN_W+2)-bit product of the significands with the hidden 1 restored, and set the exponent to exp_a+exp_b-BIAS using a signed EXP_W+2-bit intermediate.
REQ-022 SHALL normalise by shifting right one bit and incrementing the exponent when the product MSB is set.
REQ-023 SHALL round to nearest, ties to even, using guard, round and sticky bits; a rounding carry-out SHALL renormalise and increment the exponent.
REQ-024 SHALL set inexact when any discarded product bit is nonzero.
REQ-025 SHALL flush denormal inputs to zero (FTZ).
REQ-026 SHALL return a final exponent >= 2^EXP_W-1 as signed infinity with overflow=1 and inexact=1.
REQ-027 SHALL return a final exponent <= 0 as signed zero with underflow=1 and inexact=1.
REQ-028 SHALL treat any NaN operand, or inf x zero, as producing quiet NaN (exponent all ones, fraction MSB=1, other fraction bits 0, sign 0), with invalid=1 for inf x zero and for a signalling NaN input.
REQ-029 SHALL return signed infinity with no flags for inf x finite-nonzero and for inf x inf.
REQ-030 SHALL return signed zero with no flags for zero x finite.

Reset
REQ-031 SHALL, on rst=1 at a clock edge, clear all stage valid bits, output_stb=0, output_z=0 and output_flags=0.
REQ-032 SHALL discard all in-flight operations on reset mid-operation.
REQ-033 SHALL have input_ack=1 in the first cycle after reset.
REQ-034 SHALL give rst priority over input_stb and output_ack.

Structure
REQ-035 SHALL place fpu_class_t (ZERO, NORMAL, INF, QNAN, SNAN) and the flag-bit index constants in fpu_pkg, alongside the existing fpu_operation_t.
REQ-036 SHALL implement S3–S4 as sub-module fpu_norm_round, parametrised by EXP_W and MAN_W and reusable by a future adder.
REQ-037 SHALL not instantiate any vendor multiplier primitive; S2 SHALL use a behavioural multiply.

Verification
REQ-038 SHALL verify: 0x40000000 x 0x40400000 -> 0x40C00000 (6.0), flags 0000, output_stb exactly 4 cycles after acceptance.
REQ-039 SHALL verify: 0x3F800001 x 0x3F800001 -> 0x3F800002, inexact=1; and 0x3FC00000 x 0x3FC00000 -> 0x40100000, flags 0.
REQ-040 SHALL verify: 0x7F800000 x 0x00000000 -> 0x7FC00000, invalid=1; and 0xFF800000 x 0x40000000 -> 0xFF800000, flags 0.
REQ-041 SHALL verify: 0x7F000000 x 0x7F000000 -> 0x7F800000 with overflow=1 and inexact=1; and 0x00800000 x 0x00800000 -> 0x00000000 with underflow=1 and inexact=1.
REQ-042 SHALL verify: stream a=1.0..8.0 each x 0x42b1cccd with output_ack held 0 for 10 cycles -> input_ack drops while output_stb=1; then 8 ordered, correct results with no loss.
REQ-043 SHALL verify: rst asserted with 3 operations in flight -> output_stb=0 the next cycle and no stale results afterwards.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FPU types and constants.
//   fpu_operation_t : operation selector used across the FPU family
//   fpu_class_t     : operand classification produced by the unpack stage
//   FLAG_*          : bit positions within the 4-bit {invalid, overflow,
//                     underflow, inexact} flag vector
package fpu_pkg;

   typedef enum logic [1:0] {
      FPU_ADD,
      FPU_SUB,
      FPU_MUL,
      FPU_DIV
   } fpu_operation_t;

   typedef enum logic [2:0] {
      ZERO,
      NORMAL,
      INF,
      QNAN,
      SNAN
   } fpu_class_t;

   localparam int unsigned FLAG_INVALID   = 3;
   localparam int unsigned FLAG_OVERFLOW  = 2;
   localparam int unsigned FLAG_UNDERFLOW = 1;
   localparam int unsigned FLAG_INEXACT   = 0;

endpackage

// File: rtl/fpu_norm_round.sv
// Normalise (S3) and round/pack (S4) stages shared by FPU datapaths.
//   clk, rst      : rising-edge clock, synchronous active-high reset
//   en            : pipeline advance enable
//   valid         : incoming stage valid
//   sign, exp     : result sign and signed biased exponent (EXP_W+2 bits)
//   sig           : raw significand, leading one in bit P-1 or P-2
//   special*      : precomputed result that bypasses normalise/round
//   z, z_flags    : packed result and {invalid, overflow, underflow, inexact}
//   z_valid       : result valid (registered)
module fpu_norm_round
   import fpu_pkg::*;
#(
   parameter int unsigned EXP_W = 8,
   parameter int unsigned MAN_W = 23,
   localparam int unsigned W  = 1 + EXP_W + MAN_W,
   localparam int unsigned XW = EXP_W + 2,
   localparam int unsigned P  = 2*MAN_W + 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 valid,
   input  logic                 sign,
   input  logic signed [XW-1:0] exp,
   input  logic [P-1:0]         sig,
   input  logic                 special,
   input  logic [W-1:0]         special_z,
   input  logic [3:0]           special_flags,
   output logic [W-1:0]         z,
   output logic [3:0]           z_flags,
   output logic                 z_valid
);

   localparam logic signed [XW-1:0] EXP_MAX = XW'((1 << EXP_W) - 1);

   // S3: normalise so the hidden one is dropped and G/R/S are extracted
   logic signed [XW-1:0] n_exp;
   logic [MAN_W-1:0]     n_frac;
   logic                 n_g, n_r, n_s;

   always_comb begin
      if (sig[P-1]) begin
         n_exp  = exp + XW'(1);
         n_frac = sig[P-2 -: MAN_W];
         n_g    = sig[MAN_W];
         n_r    = sig[MAN_W-1];
         n_s    = |sig[MAN_W-2:0];
      end else begin
         n_exp  = exp;
         n_frac = sig[P-3 -: MAN_W];
         n_g    = sig[MAN_W-1];
         n_r    = sig[MAN_W-2];
         n_s    = |sig[MAN_W-3:0];
      end
   end

   logic                 s3_valid, s3_sign, s3_special;
   logic signed [XW-1:0] s3_exp;
   logic [MAN_W-1:0]     s3_frac;
   logic                 s3_g, s3_r, s3_s;
   logic [W-1:0]         s3_special_z;
   logic [3:0]           s3_special_flags;

   always_ff @(posedge clk) begin
      if (rst) begin
         s3_valid <= 1'b0;
      end else if (en) begin
         s3_valid         <= valid;
         s3_sign          <= sign;
         s3_exp           <= n_exp;
         s3_frac          <= n_frac;
         s3_g             <= n_g;
         s3_r             <= n_r;
         s3_s             <= n_s;
         s3_special       <= special;
         s3_special_z     <= special_z;
         s3_special_flags <= special_flags;
      end
   end

   // S4: round to nearest even, then range-check the final exponent
   logic                 round_up, carry, inexact;
   logic [MAN_W-1:0]     r_frac;
   logic signed [XW-1:0] r_exp;
   logic [W-1:0]         pack_z;
   logic [3:0]           pack_flags;

   always_comb begin
      round_up          = s3_g & (s3_r | s3_s | s3_frac[0]);
      {carry, r_frac}   = {1'b0, s3_frac} + {{MAN_W{1'b0}}, round_up};
      // carry-out leaves r_frac at zero: 1.111..1 + ulp = 10.0 -> 1.0 x 2^(e+1)
      r_exp             = s3_exp + XW'(carry);
      inexact           = s3_g | s3_r | s3_s;
      pack_flags        = '0;
      if (s3_special) begin
         pack_z     = s3_special_z;
         pack_flags = s3_special_flags;
      end else if (r_exp >= EXP_MAX) begin
         pack_z                     = {s3_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         pack_flags[FLAG_OVERFLOW]  = 1'b1;
         pack_flags[FLAG_INEXACT]   = 1'b1;
      end else if (r_exp <= 0) begin
         pack_z                     = {s3_sign, {(W-1){1'b0}}};
         pack_flags[FLAG_UNDERFLOW] = 1'b1;
         pack_flags[FLAG_INEXACT]   = 1'b1;
      end else begin
         pack_z                     = {s3_sign, r_exp[EXP_W-1:0], r_frac};
         pack_flags[FLAG_INEXACT]   = inexact;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         z_valid <= 1'b0;
         z       <= '0;
         z_flags <= '0;
      end else if (en) begin
         z_valid <= s3_valid;
         z       <= pack_z;
         z_flags <= pack_flags;
      end
   end

endmodule

// File: rtl/fpu_mult_pipe.sv
// Four-stage pipelined floating-point multiplier with strobe/ack handshake.
//   clk, rst      : rising-edge clock, synchronous active-high reset
//   input_a/b     : operands {sign, exponent, fraction}
//   input_stb/ack : operand handshake; ack is the global pipeline enable
//   output_z      : product
//   output_flags  : {invalid, overflow, underflow, inexact}
//   output_stb/ack: result handshake
// Stages: S1 unpack/classify, S2 multiply, S3/S4 in fpu_norm_round.
module fpu_mult_pipe
   import fpu_pkg::*;
#(
   parameter int unsigned EXP_W = 8,
   parameter int unsigned MAN_W = 23,
   localparam int unsigned W = 1 + EXP_W + MAN_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] input_a,
   input  logic [W-1:0] input_b,
   input  logic         input_stb,
   output logic         input_ack,
   output logic [W-1:0] output_z,
   output logic [3:0]   output_flags,
   output logic         output_stb,
   input  logic         output_ack
);

   localparam int unsigned XW = EXP_W + 2;
   localparam int unsigned P  = 2*MAN_W + 2;
   localparam logic signed [XW-1:0] BIAS = XW'((1 << (EXP_W-1)) - 1);
   localparam logic [W-1:0] QNAN_Z = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

   // Denormals classify as ZERO, giving flush-to-zero on input
   function automatic fpu_class_t classify(input logic [EXP_W-1:0] e,
                                           input logic [MAN_W-1:0] f);
      if (e == '0)          return ZERO;
      else if (e != '1)     return NORMAL;
      else if (f == '0)     return INF;
      else if (f[MAN_W-1])  return QNAN;
      else                  return SNAN;
   endfunction

   logic en;
   assign en        = !output_stb || output_ack;
   assign input_ack = en;

   // S1 combinational: classify and resolve all non-numeric outcomes
   fpu_class_t   class_a, class_b;
   logic         sign_z, nan_any, snan_any, inf_any, zero_any;
   logic         special;
   logic [W-1:0] special_z;
   logic [3:0]   special_flags;

   assign class_a  = classify(input_a[W-2 -: EXP_W], input_a[MAN_W-1:0]);
   assign class_b  = classify(input_b[W-2 -: EXP_W], input_b[MAN_W-1:0]);
   assign sign_z   = input_a[W-1] ^ input_b[W-1];
   assign snan_any = (class_a == SNAN) || (class_b == SNAN);
   assign nan_any  = snan_any || (class_a == QNAN) || (class_b == QNAN);
   assign inf_any  = (class_a == INF) || (class_b == INF);
   assign zero_any = (class_a == ZERO) || (class_b == ZERO);

   always_comb begin
      special       = 1'b1;
      special_z     = '0;
      special_flags = '0;
      if (nan_any) begin
         special_z                   = QNAN_Z;
         special_flags[FLAG_INVALID] = snan_any;
      end else if (inf_any && zero_any) begin
         special_z                   = QNAN_Z;
         special_flags[FLAG_INVALID] = 1'b1;
      end else if (inf_any) begin
         special_z = {sign_z, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end else if (zero_any) begin
         special_z = {sign_z, {(W-1){1'b0}}};
      end else begin
         special = 1'b0;
      end
   end

   logic             s1_valid, s1_sign, s1_special;
   logic [EXP_W-1:0] s1_exp_a, s1_exp_b;
   logic [MAN_W-1:0] s1_frac_a, s1_frac_b;
   logic [W-1:0]     s1_special_z;
   logic [3:0]       s1_special_flags;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
      end else if (en) begin
         s1_valid         <= input_stb;
         s1_sign          <= sign_z;
         s1_exp_a         <= input_a[W-2 -: EXP_W];
         s1_exp_b         <= input_b[W-2 -: EXP_W];
         s1_frac_a        <= input_a[MAN_W-1:0];
         s1_frac_b        <= input_b[MAN_W-1:0];
         s1_special       <= special;
         s1_special_z     <= special_z;
         s1_special_flags <= special_flags;
      end
   end

   // S2: significand multiply with hidden ones restored, biased exponent sum
   logic                 s2_valid, s2_sign, s2_special;
   logic signed [XW-1:0] s2_exp;
   logic [P-1:0]         s2_sig;
   logic [W-1:0]         s2_special_z;
   logic [3:0]           s2_special_flags;

   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid <= 1'b0;
      end else if (en) begin
         s2_valid         <= s1_valid;
         s2_sign          <= s1_sign;
         s2_sig           <= P'({1'b1, s1_frac_a}) * P'({1'b1, s1_frac_b});
         s2_exp           <= $signed({2'b00, s1_exp_a}) + $signed({2'b00, s1_exp_b}) - BIAS;
         s2_special       <= s1_special;
         s2_special_z     <= s1_special_z;
         s2_special_flags <= s1_special_flags;
      end
   end

   fpu_norm_round #(
      .EXP_W (EXP_W),
      .MAN_W (MAN_W)
   ) u_norm_round (
      .clk           (clk),
      .rst           (rst),
      .en            (en),
      .valid         (s2_valid),
      .sign          (s2_sign),
      .exp           (s2_exp),
      .sig           (s2_sig),
      .special       (s2_special),
      .special_z     (s2_special_z),
      .special_flags (s2_special_flags),
      .z             (output_z),
      .z_flags       (output_flags),
      .z_valid       (output_stb)
   );

endmodule

// File: tb/tb_fpu_mult_pipe.sv
// Directed bench for fpu_mult_pipe: vector table plus stall and reset sequences.
module tb_fpu_mult_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] input_a, input_b;
   logic        input_stb, input_ack;
   logic [31:0] output_z;
   logic [3:0]  output_flags;
   logic        output_stb, output_ack;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   fpu_mult_pipe #(
      .EXP_W (8),
      .MAN_W (23)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .input_a      (input_a),
      .input_b      (input_b),
      .input_stb    (input_stb),
      .input_ack    (input_ack),
      .output_z     (output_z),
      .output_flags (output_flags),
      .output_stb   (output_stb),
      .output_ack   (output_ack)
   );

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] z;
      logic [3:0]  f;
   } vec_t;

   localparam int NV = 21;
   vec_t vecs[NV];

   logic [31:0] s_ops[8];
   logic [31:0] s_z[8];
   logic [3:0]  s_f[8];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, got, want);
      end
   endtask

   // One isolated operation with output_ack held high; lat counts rising
   // edges from the acceptance edge (inclusive) to output_stb.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] z, output logic [3:0] f, output int lat);
      @(negedge clk);
      input_a    = a;
      input_b    = b;
      input_stb  = 1'b1;
      output_ack = 1'b1;
      @(posedge clk);
      #1 input_stb = 1'b0;
      lat = 1;
      z   = 'x;
      f   = 'x;
      while (lat < 20) begin
         @(negedge clk);
         if (output_stb) begin
            z = output_z;
            f = output_flags;
            break;
         end
         @(posedge clk);
         lat++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] z;
      logic [3:0]  f;
      int          lat;
      int          idx, got, stale;

      vecs[0]  = '{32'h40000000, 32'h40400000, 32'h40C00000, 4'h0};
      vecs[1]  = '{32'h3F800001, 32'h3F800001, 32'h3F800002, 4'h1};
      vecs[2]  = '{32'h3FC00000, 32'h3FC00000, 32'h40100000, 4'h0};
      vecs[3]  = '{32'h7F800000, 32'h00000000, 32'h7FC00000, 4'h8};
      vecs[4]  = '{32'hFF800000, 32'h40000000, 32'hFF800000, 4'h0};
      vecs[5]  = '{32'h7F000000, 32'h7F000000, 32'h7F800000, 4'h5};
      vecs[6]  = '{32'h00800000, 32'h00800000, 32'h00000000, 4'h3};
      vecs[7]  = '{32'h3F800001, 32'h3FC00000, 32'h3FC00002, 4'h1};
      vecs[8]  = '{32'h3F800003, 32'h3FC00000, 32'h3FC00004, 4'h1};
      vecs[9]  = '{32'h3F800001, 32'h3FFFFFFE, 32'h40000000, 4'h1};
      vecs[10] = '{32'h80000000, 32'h40000000, 32'h80000000, 4'h0};
      vecs[11] = '{32'h00000001, 32'hC0000000, 32'h80000000, 4'h0};
      vecs[12] = '{32'h7FC00000, 32'h3F800000, 32'h7FC00000, 4'h0};
      vecs[13] = '{32'hFF800001, 32'h3F800000, 32'h7FC00000, 4'h8};
      vecs[14] = '{32'hFF800000, 32'h7F800000, 32'hFF800000, 4'h0};
      vecs[15] = '{32'h00800000, 32'h3F800000, 32'h00800000, 4'h0};
      vecs[16] = '{32'h00800000, 32'h3F7FFFFF, 32'h00000000, 4'h3};
      vecs[17] = '{32'h7F000000, 32'h3FFFFFFF, 32'h7F7FFFFF, 4'h0};
      vecs[18] = '{32'h7F000000, 32'h40000000, 32'h7F800000, 4'h5};
      vecs[19] = '{32'h80000000, 32'h7F800000, 32'h7FC00000, 4'h8};
      vecs[20] = '{32'hC0000000, 32'h40400000, 32'hC0C00000, 4'h0};

      s_ops = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
      s_z   = '{32'h42B1CCCD, 32'h4331CCCD, 32'h4385599A, 32'h43B1CCCD,
                32'h43DE4000, 32'h4405599A, 32'h441B9333, 32'h4431CCCD};
      s_f   = '{4'h0, 4'h0, 4'h1, 4'h0, 4'h1, 4'h1, 4'h1, 4'h0};

      // Reset, with an operand offered during reset that must not be taken
      rst        = 1'b1;
      input_stb  = 1'b0;
      input_a    = '0;
      input_b    = '0;
      output_ack = 1'b0;
      repeat (2) @(negedge clk);
      input_a    = 32'h40000000;
      input_b    = 32'h40000000;
      input_stb  = 1'b1;
      output_ack = 1'b1;
      @(negedge clk);
      rst        = 1'b0;
      input_stb  = 1'b0;
      output_ack = 1'b0;
      #1;
      check("reset_stb",   32'(output_stb), 32'h0);
      check("reset_z",     output_z, 32'h0);
      check("reset_flags", 32'(output_flags), 32'h0);
      check("reset_ack",   32'(input_ack), 32'h1);
      stale = 0;
      repeat (6) begin
         @(negedge clk);
         if (output_stb) stale++;
      end
      check("reset_priority_no_output", 32'(stale), 32'h0);

      // Table of isolated operations
      for (int i = 0; i < NV; i++) begin
         run_op(vecs[i].a, vecs[i].b, z, f, lat);
         check($sformatf("vec%0d_z", i), z, vecs[i].z);
         check($sformatf("vec%0d_flags", i), 32'(f), 32'(vecs[i].f));
         check($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
      end

      // Stream 8 operands with output_ack low for the first 14 cycles:
      // 4 fill the pipe, then 10 cycles of back-pressure.
      @(negedge clk);
      idx = 0;
      got = 0;
      for (int cyc = 0; cyc < 100 && got < 8; cyc++) begin
         if (cyc > 0) @(negedge clk);
         output_ack = (cyc >= 14);
         if (idx < 8) begin
            input_a   = s_ops[idx];
            input_b   = 32'h42B1CCCD;
            input_stb = 1'b1;
         end else begin
            input_stb = 1'b0;
         end
         #1;
         if (cyc == 13) check("stall_accepted", 32'(idx), 32'd4);
         if (output_stb && !output_ack) begin
            check($sformatf("stall_ack_c%0d", cyc), 32'(input_ack), 32'h0);
            check($sformatf("stall_hold_c%0d", cyc), output_z, s_z[0]);
         end
         if (output_stb && output_ack) begin
            check($sformatf("stream%0d_z", got), output_z, s_z[got]);
            check($sformatf("stream%0d_flags", got), 32'(output_flags), 32'(s_f[got]));
            got++;
         end
         if (input_stb && input_ack) idx++;
      end
      check("stream_count", 32'(got), 32'd8);
      @(negedge clk);
      input_stb  = 1'b0;
      output_ack = 1'b1;
      repeat (3) @(negedge clk);

      // Reset with three operations in flight
      for (int i = 0; i < 3; i++) begin
         input_a   = s_ops[i];
         input_b   = 32'h40400000;
         input_stb = 1'b1;
         @(negedge clk);
      end
      rst = 1'b1;
      @(negedge clk);
      rst       = 1'b0;
      input_stb = 1'b0;
      #1;
      check("midrst_stb", 32'(output_stb), 32'h0);
      check("midrst_ack", 32'(input_ack), 32'h1);
      stale = 0;
      repeat (10) begin
         @(negedge clk);
         if (output_stb) stale++;
      end
      check("midrst_no_stale", 32'(stale), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
